// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bus shared between alu_arbiter and its clients.
// The slave modport is the arbiter's view; master is the client/ALU side.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 3,
  parameter int unsigned CCRW  = 2
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic [WIDTH-1:0] alu_n1;
  logic [WIDTH-1:0] alu_n2;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic [CCRW-1:0]  alu_ccr;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic [CCRW-1:0]  resp_ccr;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, alu_ccr, resp_ready,
    output req0_ready, req1_ready,
    output alu_n1, alu_n2, alu_op,
    output resp_valid, resp_id, resp_result, resp_ccr
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, alu_ccr, resp_ready,
    input  req0_ready, req1_ready,
    input  alu_n1, alu_n2, alu_op,
    input  resp_valid, resp_id, resp_result, resp_ccr
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one combinational ALU.
// Round-robin grant in IDLE, registered ALU operands, one settle cycle, captured
// response held until accepted. Define ALU_ARB_STATS_EN to add saturating
// 8-bit per-requester grant counters (grant_cnt0/grant_cnt1).
module alu_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 3,
  parameter int unsigned CCRW  = 2
) (
  input logic           clk,
  input logic           rst,
  alu_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]    grant_cnt0,
  output logic [7:0]    grant_cnt1
`endif
);

  typedef enum logic [1:0] {StIdle, StDrive, StCapt, StResp} state_e;

  state_e           state_q;
  logic             ptr_q;
  logic [WIDTH-1:0] n1_q;
  logic [WIDTH-1:0] n2_q;
  logic [OPW-1:0]   op_q;
  logic             id_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_result_q;
  logic [CCRW-1:0]  resp_ccr_q;
  logic             gnt0;
  logic             gnt1;

  // Grant decision: only in IDLE; the pointer breaks ties when both are valid.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      if (bus.req0_valid && (!bus.req1_valid || !ptr_q)) begin
        gnt0 = 1'b1;
      end else if (bus.req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.alu_n1      = n1_q;
  assign bus.alu_n2      = n2_q;
  assign bus.alu_op      = op_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_ccr    = resp_ccr_q;

  // Sequencer: latch operands on grant, settle, capture ALU outputs, hold response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= 1'b0;
      n1_q          <= '0;
      n2_q          <= '0;
      op_q          <= '0;
      id_q          <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_ccr_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt0) begin
            n1_q    <= bus.req0_a;
            n2_q    <= bus.req0_b;
            op_q    <= bus.req0_op;
            id_q    <= 1'b0;
            ptr_q   <= 1'b1;
            state_q <= StDrive;
          end else if (gnt1) begin
            n1_q    <= bus.req1_a;
            n2_q    <= bus.req1_b;
            op_q    <= bus.req1_op;
            id_q    <= 1'b1;
            ptr_q   <= 1'b0;
            state_q <= StDrive;
          end
        end
        StDrive: state_q <= StCapt;
        StCapt: begin
          resp_result_q <= bus.alu_result;
          resp_ccr_q    <= bus.alu_ccr;
          resp_id_q     <= id_q;
          resp_valid_q  <= 1'b1;
          state_q       <= StResp;
        end
        StResp: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt0_q;
  logic [7:0] cnt1_q;

  // Saturating grant counters; they stick at 255 rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      if (gnt0 && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
      if (gnt1 && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model (busy flag, cycles since grant, round-robin pointer).
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

`ifdef ALU_ARB_STATS_EN
  logic [7:0] gc0;
  logic [7:0] gc1;
`endif

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
`endif
  );

  // Stand-in ALU: ccr = {carry, overflow}.
  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = 5'd0;
    r = 4'd0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0];
        c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[3:0];
        c = s[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin
        r = {a[2:0], 1'b0};
        c = a[3];
      end
      default: begin
        r = {1'b0, a[3:1]};
        c = a[0];
      end
    endcase
    return {c, v, r};
  endfunction

  assign {bus.alu_ccr, bus.alu_result} = alu_f(bus.alu_n1, bus.alu_n2, bus.alu_op);

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy;
  int         m_age;   // cycles since the grant edge, 3 = response presented
  bit         m_ptr;
  bit         m_id;
  logic [3:0] m_a, m_b;
  logic [2:0] m_op;
  logic       m_rid;
  logic [3:0] m_rres;
  logic [1:0] m_rccr;
  int         m_cnt0, m_cnt1;
  int         grants[$];

  function automatic bit mr0();
    return !m_busy && bus.req0_valid && (!bus.req1_valid || !m_ptr);
  endfunction

  function automatic bit mr1();
    return !m_busy && bus.req1_valid && (!bus.req0_valid || m_ptr);
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_ptr  <= 1'b0;
      m_id   <= 1'b0;
      m_a    <= '0;
      m_b    <= '0;
      m_op   <= '0;
      m_rid  <= 1'b0;
      m_rres <= '0;
      m_rccr <= '0;
      m_cnt0 <= 0;
      m_cnt1 <= 0;
    end else if (!m_busy) begin
      if (mr0()) begin
        m_busy <= 1'b1; m_age <= 1; m_ptr <= 1'b1; m_id <= 1'b0;
        m_a <= bus.req0_a; m_b <= bus.req0_b; m_op <= bus.req0_op;
        m_cnt0 <= m_cnt0 + 1;
        grants.push_back(0);
      end else if (mr1()) begin
        m_busy <= 1'b1; m_age <= 1; m_ptr <= 1'b0; m_id <= 1'b1;
        m_a <= bus.req1_a; m_b <= bus.req1_b; m_op <= bus.req1_op;
        m_cnt1 <= m_cnt1 + 1;
        grants.push_back(1);
      end
    end else if (m_age == 1) begin
      m_age <= 2;
    end else if (m_age == 2) begin
      m_age <= 3;
      {m_rccr, m_rres} <= alu_f(m_a, m_b, m_op);
      m_rid <= m_id;
    end else if (bus.resp_ready) begin
      m_busy <= 1'b0;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    chk("req0_ready", bus.req0_ready, mr0());
    chk("req1_ready", bus.req1_ready, mr1());
    chk("alu_n1", bus.alu_n1, m_a);
    chk("alu_n2", bus.alu_n2, m_b);
    chk("alu_op", bus.alu_op, m_op);
    chk("resp_valid", bus.resp_valid, m_busy && (m_age == 3));
    chk("resp_id", bus.resp_id, m_rid);
    chk("resp_result", bus.resp_result, m_rres);
    chk("resp_ccr", bus.resp_ccr, m_rccr);
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", gc0, sat(m_cnt0));
    chk("grant_cnt1", gc1, sat(m_cnt1));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set0(input bit v, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] op);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
  endtask

  task automatic set1(input bit v, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] op);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
  endtask

  // Called at a negedge; returns at a negedge showing the response.
  task automatic wait_resp();
    for (int i = 0; i < 20; i++) begin
      if (bus.resp_valid === 1'b1) return;
      @(negedge clk);
    end
    n_checks++;
    n_err++;
    $display("FAIL resp_timeout: got resp_valid=0 expected 1 within 20 cycles");
  endtask

  // Called at a negedge; returns at a negedge with the model idle.
  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (!m_busy) return;
      @(negedge clk);
    end
    n_checks++;
    n_err++;
    $display("FAIL drain_timeout: got busy expected idle within 20 cycles");
  endtask

  // One random cycle: hold pending requests, sometimes withdraw, refill after accept.
  task automatic rnd_step(input int pv, input int pdrop, input int prr);
    bit acc0, acc1;
    acc0 = mr0();
    acc1 = mr1();
    tick();
    if (bus.req0_valid && !acc0) begin
      if ($urandom_range(99) < pdrop) bus.req0_valid = 1'b0;
    end else begin
      set0($urandom_range(99) < pv, 4'($urandom), 4'($urandom), 3'($urandom));
    end
    if (bus.req1_valid && !acc1) begin
      if ($urandom_range(99) < pdrop) bus.req1_valid = 1'b0;
    end else begin
      set1($urandom_range(99) < pv, 4'($urandom), 4'($urandom), 3'($urandom));
    end
    bus.resp_ready = $urandom_range(99) < prr;
    @(negedge clk);
  endtask

  initial begin
    set0(1'b0, 4'd0, 4'd0, 3'd0);
    set1(1'b0, 4'd0, 4'd0, 3'd0);
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_alu_n1", bus.alu_n1, 0);
    chk("rst_resp_result", bus.resp_result, 0);
    @(posedge clk);
    tick();
    rst = 1'b0;

    // Single request: 3 + 5 = 8, overflow set.
    set0(1'b1, 4'b0011, 4'b0101, 3'b000);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready0", bus.req0_ready, 1);
    chk("single_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("single_n1", bus.alu_n1, 4'b0011);
    chk("single_n2", bus.alu_n2, 4'b0101);
    chk("single_op", bus.alu_op, 3'b000);
    chk("single_capt_valid", bus.resp_valid, 0);
    @(negedge clk);
    chk("single_capt_valid2", bus.resp_valid, 0);
    @(negedge clk);
    chk("single_resp_valid", bus.resp_valid, 1);
    chk("single_resp_id", bus.resp_id, 0);
    chk("single_result", bus.resp_result, 4'b1000);
    chk("single_ccr", bus.resp_ccr, 2'b01);
    @(negedge clk);
    chk("single_back_idle", bus.resp_valid, 0);

    // Carry pass-through: 15 + 1 = 0 with carry.
    tick();
    set1(1'b1, 4'b1111, 4'b0001, 3'b000);
    @(negedge clk);
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    wait_resp();
    chk("carry_id", bus.resp_id, 1);
    chk("carry_result", bus.resp_result, 4'b0000);
    chk("carry_ccr", bus.resp_ccr, 2'b10);
    @(negedge clk);

    // Contention: both continuously valid, grants must alternate.
    grants.delete();
    tick();
    set0(1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
    set1(1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      bit acc0, acc1;
      if (grants.size() >= 6) break;
      acc0 = mr0();
      acc1 = mr1();
      tick();
      if (acc0) set0(1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
      if (acc1) set1(1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
      @(negedge clk);
    end
    chk("contention_count", grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
      chk($sformatf("contention_grant%0d", i), grants[i], i % 2);
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    drain();

    // Backpressure: 6 + 7 = 13 held for 5 cycles while req1 waits.
    tick();
    bus.resp_ready = 1'b0;
    set0(1'b1, 4'd6, 4'd7, 3'd0);
    @(negedge clk);
    tick();
    bus.req0_valid = 1'b0;
    set1(1'b1, 4'd9, 4'd2, 3'd1);
    @(negedge clk);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.resp_valid, 1);
      chk("bp_id", bus.resp_id, 0);
      chk("bp_result", bus.resp_result, 4'd13);
      chk("bp_ccr", bus.resp_ccr, 2'b01);
      chk("bp_ready0", bus.req0_ready, 0);
      chk("bp_ready1", bus.req1_ready, 0);
      chk("bp_n1", bus.alu_n1, 4'd6);
      chk("bp_n2", bus.alu_n2, 4'd7);
      @(negedge clk);
    end
    tick();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_released_valid", bus.resp_valid, 0);
    chk("bp_released_ready1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    drain();

    // Reset while in CAPT, then pointer must be back at requester 0.
    tick();
    set0(1'b1, 4'd2, 4'd3, 3'd4);
    @(negedge clk);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", bus.resp_valid, 0);
    chk("midrst_resp_result", bus.resp_result, 0);
    chk("midrst_resp_ccr", bus.resp_ccr, 0);
    chk("midrst_resp_id", bus.resp_id, 0);
    chk("midrst_n1", bus.alu_n1, 0);
    chk("midrst_n2", bus.alu_n2, 0);
    chk("midrst_op", bus.alu_op, 0);
    set0(1'b1, 4'd1, 4'd1, 3'd0);
    set1(1'b1, 4'd2, 4'd2, 3'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_first_ready0", bus.req0_ready, 1);
    chk("midrst_first_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    drain();

    // Randomized traffic, checked by the per-cycle comparator.
    for (int i = 0; i < 3000; i++) rnd_step(70, 10, 60);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    drain();

`ifdef ALU_ARB_STATS_EN
    // Saturation: 300 grants to requester 1 only.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    set1(1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
    @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      bit acc1;
      if (m_cnt1 >= 300) break;
      acc1 = mr1();
      tick();
      if (acc1) set1(1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
      @(negedge clk);
    end
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    drain();
    chk("stats_cnt1_sat", gc1, 255);
    chk("stats_cnt0_zero", gc0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 4-bit ALU (inputs n1, n2, operator; outputs result, CCR = {carry, overflow}) between two requesters.
- Each requester uses a valid/ready request channel and receives a tagged response carrying the result and CCR.
- The block owns the ALU input bus. It registers operands, gives the ALU one full cycle to settle, captures the outputs, and holds the response until it is accepted.
- Sits between the ALU instance and any client logic, such as sequencers or test drivers, that needs ALU operations.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- OPW, 3, operator code width.
- CCRW, 2, condition-code width; bit 1 = carry, bit 0 = overflow.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand 1
- req0_b  input  WIDTH  requester 0 operand 2
- req0_op  input  OPW  requester 0 operator
- req1_valid  input  1  requester 1 has an operation pending
- req1_ready  output  1  requester 1 operation accepted this cycle
- req1_a  input  WIDTH  requester 1 operand 1
- req1_b  input  WIDTH  requester 1 operand 2
- req1_op  input  OPW  requester 1 operator
- alu_n1  output  WIDTH  to ALU n1
- alu_n2  output  WIDTH  to ALU n2
- alu_op  output  OPW  to ALU operator
- alu_result  input  WIDTH  from ALU result
- alu_ccr  input  CCRW  from ALU CCR
- resp_valid  output  1  response available
- resp_ready  input  1  response consumer accepts
- resp_id  output  1  requester that issued the response
- resp_result  output  WIDTH  captured ALU result
- resp_ccr  output  CCRW  captured ALU CCR

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, priority pointer = 0.
  - alu_n1/alu_n2/alu_op = 0; resp_valid/resp_id/resp_result/resp_ccr = 0.
  - An in-flight operation or pending response is discarded.
- FSM states: IDLE -> DRIVE -> CAPT -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational and is high only for the grant winner, only in IDLE, and only when that requester's valid is high.
  - Grant rules:
    - Only one valid: that requester wins.
    - Both valid: the requester selected by the pointer wins.
    - Neither valid: stay in IDLE.
  - On grant:
    - Latch a, b, op and id into the operand registers.
    - Pointer = ~winner id.
    - Next state DRIVE.
- ALU drive: alu_n1/alu_n2/alu_op always come from the operand registers, never combinationally from request inputs. They are held stable from the DRIVE state until the next grant.
- DRIVE: one settle cycle; next state CAPT.
- CAPT:
  - Register alu_result, alu_ccr and the latched id into the response registers.
  - Next state RESP.
- RESP:
  - resp_valid = 1; all resp_* outputs are held stable.
  - resp_ready = 1: next state IDLE, resp_valid falls on that edge.
- Timing:
  - Latency: accept edge E0; resp_valid rises after edge E0+2.
  - Zero-wait-state throughput: one operation per 4 cycles.
  - In RESP, resp_ready already high: a new grant is possible in the cycle immediately after resp_valid falls.
- Request-channel rules:
  - No request is accepted outside IDLE; both readys are 0.
  - A requester holds valid and data stable until ready.
  - Dropping valid before ready withdraws the request with no side effects.
- Arithmetic and flags are entirely the ALU's. Result and CCR are passed through unmodified at full width, with no sign extension or masking.
- Simultaneous events:
  - A requester that re-asserts valid right after service loses to a waiting peer because of the pointer. No starvation: with both requesters continuously valid, grants strictly alternate.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (8 bits each).
  - Each counter increments on every grant to its requester.
  - Counters saturate at 255 and do not wrap.
  - Both reset to 0 on rst.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: assert rst while in CAPT -> all outputs 0 immediately; after release, the first grant goes to req0 when both are valid.
- Single request: req0 a=4'b0011, b=4'b0101, op=3'b000, resp_ready=1 -> req0_ready pulses 1 cycle; alu_n1/alu_n2/alu_op show 0011/0101/000 from the next cycle on; resp_valid after E0+2 with resp_id=0, result and CCR equal to the ALU's outputs for those inputs.
- Contention: both valid continuously for 6 operations -> grant order 0,1,0,1,0,1; each resp_id matches its issuer.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stable, both readys 0, alu_n1/alu_n2 unchanged; resp_ready=1 -> IDLE next cycle.
- Carry/overflow pass-through: a=4'b1111, b=4'b0001 with the ALU add code -> resp_result=0000, resp_ccr matches alu_ccr (carry bit 1).
- With ALU_ARB_STATS_EN: 300 grants to req1 -> grant_cnt1=255 (saturated), grant_cnt0=0.
